ififo_loader: RTL

Fetches a contiguous block of activation vectors from the activation SRAM and pushes them, one `row*bw`-bit vector per write, into the input FIFO that feeds the west side of the MAC array. It is a start/done-controlled DMA-style stage sitting directly upstream of the input FIFO. It honours the FIFO's full backpressure across the SRAM's 1-cycle read latency using a one-entry skid buffer, so no vector is dropped or reordered.

---
 rtl/ififo_loader_pkg.sv | 20 ++
 rtl/ififo_loader_skid.sv | 47 ++++
 rtl/ififo_loader.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/ififo_loader_pkg.sv
// ififo_loader_pkg: shared state encoding and default widths for the
// activation-SRAM to input-FIFO loader.
package ififo_loader_pkg;

    localparam int ROW_DEF    = 8;
    localparam int BW_DEF     = 4;
    localparam int ADDR_W_DEF = 11;
    localparam int LEN_W_DEF  = 11;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE,
        ST_RUN  = RUN,
        ST_DONE = DONE
    } state_e;

endpackage

// File: rtl/ififo_loader_skid.sv
// ififo_loader_skid: one-entry holding register that catches an SRAM
// return word when the FIFO is full, and hands it back when drained.
module ififo_loader_skid
    import ififo_loader_pkg::*;
#(
    parameter int W = ROW_DEF * BW_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         drain,
    output logic         valid,
    output logic [W-1:0] data
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    // Load wins over drain; the loader never requests both in one cycle.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (drain) begin
            valid_d = 1'b0;
        end
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end
    end

    // Holding register state.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/ififo_loader.sv
// ififo_loader: reads len consecutive vectors from the activation SRAM,
// starting at base_addr, and writes them in order into the input FIFO.
// A one-entry skid buffer absorbs the SRAM's 1-cycle read latency when the
// FIFO raises full, so nothing is dropped or reordered.
// Optional build macro IFIFO_LOADER_STALL_CNT_EN adds a 16-bit saturating
// stall_cnt output counting RUN cycles with fifo_full high.
//
// state | meaning
// IDLE  | waiting for start; outputs quiet
// RUN   | issuing reads and writing the FIFO until all len vectors written
// DONE  | one-cycle done pulse, then back to IDLE
module ififo_loader
    import ififo_loader_pkg::*;
#(
    parameter int row    = ROW_DEF,
    parameter int bw     = BW_DEF,
    parameter int addr_w = ADDR_W_DEF,
    parameter int len_w  = LEN_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [addr_w-1:0]   base_addr,
    input  logic [len_w-1:0]    len,
    output logic                busy,
    output logic                done,
    output logic                mem_cen,
    output logic                mem_wen,
    output logic [addr_w-1:0]   mem_addr,
    input  logic [row*bw-1:0]   mem_q,
    input  logic                fifo_full,
    output logic                fifo_wr,
    output logic [row*bw-1:0]   fifo_in
`ifdef IFIFO_LOADER_STALL_CNT_EN
    ,
    output logic [15:0]         stall_cnt
`endif
);

    state_e              state_q, state_d;
    logic [addr_w-1:0]   base_q, base_d;
    logic [len_w-1:0]    len_q, len_d;
    logic [len_w-1:0]    issued_q, issued_d;
    logic [len_w-1:0]    written_q, written_d;
    logic                rd_pend_q, rd_pend_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                issue;
    logic                wr_skid;
    logic                wr_direct;
    logic                skid_load;
    logic                skid_valid;
    logic [row*bw-1:0]   skid_data;

    ififo_loader_skid #(
        .W (row*bw)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .load      (skid_load),
        .load_data (mem_q),
        .drain     (wr_skid),
        .valid     (skid_valid),
        .data      (skid_data)
    );

    // Read issue and write path; the fifo_full path is deliberately
    // combinational. A draining skid frees the slot for this cycle's read,
    // so a single full cycle costs exactly one cycle of throughput.
    always_comb begin
        wr_skid   = skid_valid && !fifo_full;
        wr_direct = rd_pend_q && !skid_valid && !fifo_full;
        skid_load = rd_pend_q && fifo_full;
        issue     = (state_q == ST_RUN) && (issued_q < len_q) && !fifo_full
                    && (!skid_valid || wr_skid);
        fifo_wr   = wr_skid || wr_direct;
        fifo_in   = skid_valid ? skid_data : mem_q;
        mem_cen   = !issue;
        mem_wen   = 1'b1;
        mem_addr  = issue ? (base_q + addr_w'(issued_q)) : '0;
    end

    // Next-state, counters and registered status outputs.
    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        len_d     = len_q;
        issued_d  = issued_q + len_w'(issue);
        written_d = written_q + len_w'(fifo_wr);
        rd_pend_d = issue;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d    = base_addr;
                    len_d     = len;
                    issued_d  = '0;
                    written_d = '0;
                    state_d   = (len != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (written_d == len_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // Single state register for the FSM, counters and outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            base_q    <= '0;
            len_q     <= '0;
            issued_q  <= '0;
            written_q <= '0;
            rd_pend_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            len_q     <= len_d;
            issued_q  <= issued_d;
            written_q <= written_d;
            rd_pend_q <= rd_pend_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;

`ifdef IFIFO_LOADER_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    // Saturating count of RUN cycles lost to a full FIFO; an accepted start clears it.
    always_comb begin
        stall_d = stall_q;
        if (state_q == ST_IDLE && start) begin
            stall_d = '0;
        end else if (state_q == ST_RUN && fifo_full && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule
